// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - armed circular capture of ADC bytes with level trigger and UART dump
//
// Sits between the downsampler and uart_tx. Once armed, accepted samples are
// written into a circular RAM. After pPreTrig samples it watches for a rising
// crossing of pTrigLevel, fills the post-trigger window and then streams one
// full buffer (oldest pre-trigger sample first) to uart_tx, one byte per
// DV/Done handshake.
//
// Optional feature macro: TRIG_CAPTURE_HEADER_EN
//   defined   -> dump is prefixed with A5 5A <pPreTrig[7:0]> (DEPTH+3 bytes)
//   undefined -> dump is exactly DEPTH bytes, no header logic
//
// Ports:
//   iClk        system clock
//   iRst_n      asynchronous active-low reset
//   iData       downsampled ADC byte
//   iData_Valid one-cycle strobe qualifying iData
//   iArm        one-cycle capture start request (honoured in IDLE only)
//   iTx_Active  uart_tx busy indication
//   iTx_Done    uart_tx one-cycle byte-complete pulse
//   oTx_DV      one-cycle send strobe to uart_tx
//   oTx_Byte    byte to uart_tx, held from oTx_DV until iTx_Done
//   oArmed      registered: PRE or WAIT_TRIG
//   oTriggered  registered: POST, SEND or WAIT_DONE
//   oBusy       registered: any state but IDLE

module trigger_capture #(
  parameter int pAddrWidth = 8,
  parameter int pPreTrig   = 64,
  parameter int pTrigLevel = 128
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iData,
  input  logic       iData_Valid,
  input  logic       iArm,
  input  logic       iTx_Active,
  input  logic       iTx_Done,
  output logic       oTx_DV,
  output logic [7:0] oTx_Byte,
  output logic       oArmed,
  output logic       oTriggered,
  output logic       oBusy
);

  localparam int DEPTH = 1 << pAddrWidth;
  localparam int CW    = pAddrWidth + 1;

  localparam logic [CW-1:0]         PRE_CNT  = CW'(pPreTrig);
  localparam logic [CW-1:0]         POST_CNT = CW'(DEPTH - pPreTrig - 1);
  localparam logic [CW-1:0]         DUMP_CNT = CW'(DEPTH);
  localparam logic [pAddrWidth-1:0] PRE_OFS  = pAddrWidth'(pPreTrig);
  localparam logic [7:0]            TRIG_LVL = 8'(pTrigLevel);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]            mem [DEPTH];
  logic [pAddrWidth-1:0] wr_ptr, rd_ptr, trig_addr;
  logic [CW-1:0]         cnt, byte_cnt;
  logic [CW-1:0]         cnt_inc, byte_cnt_inc;
  logic [7:0]            prev, rd_data, tx_byte;
  logic                  rd_ok, accept, trig_hit, tx_fire, last_byte;

  assign accept       = iData_Valid &&
                        (state == S_PRE || state == S_WAIT_TRIG || state == S_POST);
  // Rising crossing: previous accepted sample strictly below, current at or above.
  assign trig_hit     = (prev < TRIG_LVL) && (iData >= TRIG_LVL);
  assign cnt_inc      = cnt + 1'b1;
  assign byte_cnt_inc = byte_cnt + 1'b1;

`ifdef TRIG_CAPTURE_HEADER_EN
  logic [1:0] hdr_cnt;
  logic       hdr_phase;

  assign hdr_phase = (hdr_cnt != 2'd3);

  always_comb begin
    tx_byte = rd_data;
    case (hdr_cnt)
      2'd0:    tx_byte = 8'hA5;
      2'd1:    tx_byte = 8'h5A;
      2'd2:    tx_byte = 8'(pPreTrig);
      default: tx_byte = rd_data;
    endcase
  end

  assign last_byte = !hdr_phase && (byte_cnt_inc == DUMP_CNT);
`else
  assign tx_byte   = rd_data;
  assign last_byte = (byte_cnt_inc == DUMP_CNT);
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_fire   = 1'b0;
    case (state)
      S_IDLE:      if (iArm) state_nxt = S_PRE;
      S_PRE:       if (accept && cnt_inc == PRE_CNT) state_nxt = S_WAIT_TRIG;
      S_WAIT_TRIG: if (accept && trig_hit) state_nxt = S_POST;
      S_POST:      if (accept && cnt_inc == POST_CNT) state_nxt = S_SEND;
      S_SEND: begin
        // rd_ok marks that rd_data reflects the current rd_ptr.
        if (rd_ok && !iTx_Active) begin
          tx_fire   = 1'b1;
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (iTx_Done) state_nxt = last_byte ? S_IDLE : S_SEND;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_addr  <= '0;
      cnt        <= '0;
      byte_cnt   <= '0;
      prev       <= '0;
      rd_ok      <= 1'b0;
      oTx_DV     <= 1'b0;
      oTx_Byte   <= '0;
      oArmed     <= 1'b0;
      oTriggered <= 1'b0;
      oBusy      <= 1'b0;
`ifdef TRIG_CAPTURE_HEADER_EN
      hdr_cnt    <= '0;
`endif
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        prev   <= iData;
      end

      rd_ok  <= (state == S_SEND) && !tx_fire;
      oTx_DV <= tx_fire;
      if (tx_fire) oTx_Byte <= tx_byte;

      oArmed     <= (state == S_PRE) || (state == S_WAIT_TRIG);
      oTriggered <= (state == S_POST) || (state == S_SEND) || (state == S_WAIT_DONE);
      oBusy      <= (state != S_IDLE);

      case (state)
        S_IDLE: if (iArm) cnt <= '0;
        S_PRE:  if (accept) cnt <= cnt_inc;
        S_WAIT_TRIG: begin
          if (accept && trig_hit) begin
            trig_addr <= wr_ptr;
            cnt       <= '0;
          end
        end
        S_POST: begin
          if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == POST_CNT) begin
              rd_ptr   <= trig_addr - PRE_OFS;
              byte_cnt <= '0;
`ifdef TRIG_CAPTURE_HEADER_EN
              hdr_cnt  <= '0;
`endif
            end
          end
        end
        S_WAIT_DONE: begin
          if (iTx_Done) begin
`ifdef TRIG_CAPTURE_HEADER_EN
            if (hdr_phase) begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end else begin
              rd_ptr   <= rd_ptr + 1'b1;
              byte_cnt <= byte_cnt_inc;
            end
`else
            rd_ptr   <= rd_ptr + 1'b1;
            byte_cnt <= byte_cnt_inc;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Sample RAM: one write port, synchronous read port.
  always_ff @(posedge iClk) begin
    if (accept) mem[wr_ptr] <= iData;
    rd_data <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_trigger_capture.sv
// tb/tb_trigger_capture.sv - self-checking bench for trigger_capture

module tb_trigger_capture;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int PRE   = 2;
  localparam int LVL   = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       data_valid;
  logic       arm;
  logic       tx_active;
  logic       tx_done;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       armed, triggered, busy;

  logic       uart_act = 1'b0;
  logic       hold_act = 1'b0;
  assign tx_active = uart_act | hold_act;

  trigger_capture #(
    .pAddrWidth(AW),
    .pPreTrig  (PRE),
    .pTrigLevel(LVL)
  ) dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .iData      (data),
    .iData_Valid(data_valid),
    .iArm       (arm),
    .iTx_Active (tx_active),
    .iTx_Done   (tx_done),
    .oTx_DV     (tx_dv),
    .oTx_Byte   (tx_byte),
    .oArmed     (armed),
    .oTriggered (triggered),
    .oBusy      (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard of bytes the UART should receive, in order.
  logic [7:0] sb[$];

  // Behavioural reference of the capture sequence.
  typedef enum {M_IDLE, M_PRE, M_WAIT, M_POST, M_DUMP} mstate_t;
  mstate_t    m_state = M_IDLE;
  int         m_cnt   = 0;
  logic [7:0] m_prev  = 8'd0;
  logic [7:0] hist[$];

  // UART model: Active for 10 cycles after each DV, then a one-cycle Done.
  int busy_cyc    = 0;
  int dv_cnt      = 0;
  int done_cnt    = 0;
  bit outstanding = 1'b0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (tx_done) tx_done = 1'b0;
    if (tx_dv === 1'b1) begin
      dv_cnt++;
      check("dv_while_active", tx_active, 0);
      check("dv_without_done", outstanding, 0);
      outstanding = 1'b1;
      n_total++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL unexpected_byte: observed %0h expected no byte", tx_byte);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        check("uart_byte", tx_byte, exp_b);
      end
      uart_act = 1'b1;
      busy_cyc = 10;
    end else if (busy_cyc > 0) begin
      busy_cyc--;
      if (busy_cyc == 0) begin
        uart_act    = 1'b0;
        tx_done     = 1'b1;
        done_cnt++;
        outstanding = 1'b0;
      end
    end
  end

  task automatic push_dump();
`ifdef TRIG_CAPTURE_HEADER_EN
    sb.push_back(8'hA5);
    sb.push_back(8'h5A);
    sb.push_back(8'(PRE));
`endif
    for (int i = hist.size() - DEPTH; i < hist.size(); i++) sb.push_back(hist[i]);
  endtask

  task automatic arm_pulse(input bit with_data, input logic [7:0] d);
    @(negedge clk);
    arm        = 1'b1;
    data       = d;
    data_valid = with_data;
    if (m_state == M_IDLE) begin
      m_state = M_PRE;
      m_cnt   = 0;
      hist.delete();
    end
    @(negedge clk);
    arm        = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d);
    @(negedge clk);
    data       = d;
    data_valid = 1'b1;
    if (m_state == M_PRE || m_state == M_WAIT || m_state == M_POST) begin
      hist.push_back(d);
      case (m_state)
        M_PRE: begin
          m_cnt++;
          if (m_cnt == PRE) m_state = M_WAIT;
        end
        M_WAIT: begin
          if (m_prev < 8'(LVL) && d >= 8'(LVL)) begin
            m_state = M_POST;
            m_cnt   = 0;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt == DEPTH - PRE - 1) begin
            m_state = M_DUMP;
            push_dump();
          end
        end
      endcase
      m_prev = d;
    end
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic chk_flags(input string tag);
    @(negedge clk);
    check({tag, "_armed"}, armed, (m_state == M_PRE || m_state == M_WAIT));
    check({tag, "_trig"},  triggered, (m_state == M_POST || m_state == M_DUMP));
    check({tag, "_busy"},  busy, (m_state != M_IDLE));
  endtask

  task automatic wait_dump(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_all_bytes_sent"}, sb.size(), 0);
    check({tag, "_busy_last_byte"}, busy, 1);
    repeat (20) @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
    m_state = M_IDLE;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {tx_dv, tx_byte, armed, triggered, busy}, 0);
    m_state = M_IDLE;
    m_prev  = 8'd0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int dv0;
    int d0;
    int t;
    rst_n      = 1'b0;
    data       = 8'd0;
    data_valid = 1'b0;
    arm        = 1'b0;
    tx_done    = 1'b0;
    repeat (3) @(negedge clk);
    check("init_outputs", {tx_dv, tx_byte, armed, triggered, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic capture: trigger on 200.
    arm_pulse(1'b0, 8'd0);
    chk_flags("basic_arm");
    feed(8'd10); feed(8'd20);
    feed(8'd30);
    chk_flags("basic_wait");
    feed(8'd200);
    chk_flags("basic_post");
    feed(8'd40); feed(8'd50); feed(8'd60); feed(8'd70); feed(8'd80);
    wait_dump("basic");

    // No false trigger without a below-to-at-or-above crossing; 128 counts.
    arm_pulse(1'b0, 8'd0);
    feed(8'd200); feed(8'd210);
    feed(8'd220); feed(8'd130); feed(8'd140);
    chk_flags("nofalse_hi");
    feed(8'd100);
    chk_flags("nofalse_lo");
    feed(8'd128);
    chk_flags("nofalse_eq");
    feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4); feed(8'd5);
    wait_dump("nofalse");

    // Ignored arm/data during POST and SEND, plus backpressure at SEND entry.
    arm_pulse(1'b0, 8'd0);
    feed(8'h30); feed(8'h40); feed(8'h50); feed(8'hC0);
    arm_pulse(1'b0, 8'd0);
    feed(8'h61); feed(8'h62); feed(8'h63); feed(8'h64);
    hold_act = 1'b1;
    feed(8'h65);
    dv0 = dv_cnt;
    repeat (10) @(negedge clk);
    arm_pulse(1'b0, 8'd0);
    repeat (10) @(negedge clk);
    feed(8'h99);
    repeat (24) @(negedge clk);
    check("bp_no_dv", dv_cnt - dv0, 0);
    check("bp_still_trig", triggered, 1);
    hold_act = 1'b0;
    repeat (11) @(negedge clk);
    check("bp_one_dv", dv_cnt - dv0, 1);
    wait_dump("ignored");

    // Reset in the middle of a dump.
    arm_pulse(1'b0, 8'd0);
    feed(8'h70); feed(8'h71); feed(8'hF0);
    feed(8'hA1); feed(8'hA2); feed(8'hA3); feed(8'hA4); feed(8'hA5);
    d0 = done_cnt;
    t  = 0;
    while (done_cnt < d0 + 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("middump_three_done", done_cnt - d0, 3);
    do_reset();
    dv0 = dv_cnt;
    repeat (60) @(negedge clk);
    check("after_reset_no_dv", dv_cnt - dv0, 0);
    check("after_reset_idle", {armed, triggered, busy}, 0);

    // Wrap-around: trigger lands on the last address so the read wraps.
    arm_pulse(1'b1, 8'h11);
    feed(8'd1); feed(8'd2);
    feed(8'd3); feed(8'd4); feed(8'd5); feed(8'd6); feed(8'd7);
    feed(8'h90);
    feed(8'h21); feed(8'h22); feed(8'h23); feed(8'h24); feed(8'h25);
    wait_dump("wrap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
Name: trigger_capture

Overview:
- Capture stage between `downsampling` and `uart_tx`. It replaces the direct valid-to-UART path, which drops bytes while the UART is busy.
- Once armed, it records downsampled ADC bytes into a circular RAM and waits for a rising-edge level trigger.
- It fills the post-trigger window, then streams exactly one buffer (pre- plus post-trigger samples) to `uart_tx` using a proper DV/Done handshake.

Parameters:
- pAddrWidth, 8: RAM address width; DEPTH = 2**pAddrWidth bytes per capture.
- pPreTrig, 64: number of samples kept before the trigger sample; legal range 1..DEPTH-2.
- pTrigLevel, 128: unsigned 8-bit trigger threshold.

Ports:
- iClk  in  1  system clock (100 MHz).
- iRst_n  in  1  asynchronous active-low reset.
- iData  in  8  downsampled ADC byte.
- iData_Valid  in  1  one-cycle strobe qualifying iData.
- iArm  in  1  one-cycle request to start a capture.
- iTx_Active  in  1  from uart_tx o_Tx_Active.
- iTx_Done  in  1  from uart_tx o_Tx_Done (one-cycle pulse).
- oTx_DV  out  1  one-cycle send strobe to uart_tx i_Tx_DV.
- oTx_Byte  out  8  byte to uart_tx i_Tx_Byte; stable from oTx_DV until iTx_Done.
- oArmed  out  1  high in PRE and WAIT_TRIG.
- oTriggered  out  1  high in POST, SEND and WAIT_DONE.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Clock and reset: one clock (iClk); reset is asynchronous and active-low (iRst_n).
  - Asserting iRst_n=0 forces state IDLE and clears all outputs, write pointer, read pointer, counters and the previous-sample register to 0.
  - This applies mid-capture and mid-dump. A byte already handed to uart_tx completes on the line; its iTx_Done is ignored.
- RAM: DEPTH x 8, one write port and one synchronous read port (read data appears 1 cycle after the address). Pointers wrap modulo DEPTH.
- Sample write: each iData_Valid in PRE, WAIT_TRIG or POST writes iData at wr_ptr, then wr_ptr+1. iData_Valid in IDLE, SEND or WAIT_DONE is ignored.
- prev register: updated with iData on every accepted sample.
- IDLE: iArm=1 clears cnt and goes to PRE. iArm in any other state is ignored.
- PRE: on each accepted sample, cnt+1. When cnt reaches pPreTrig after a write, go to WAIT_TRIG. No trigger is evaluated in PRE.
- WAIT_TRIG: trigger fires when prev < pTrigLevel and iData >= pTrigLevel, evaluated on the same accepted sample.
  - On trigger: the sample is written, trig_addr = wr_ptr before increment, cnt cleared, go to POST.
  - Level equal to the threshold on both samples is not a trigger.
- POST: count accepted samples. After DEPTH-pPreTrig-1 samples, set rd_ptr = trig_addr - pPreTrig (mod DEPTH), clear byte count, go to SEND.
- SEND:
  - Present rd_ptr to the RAM.
  - When read data is valid (1 cycle later) and iTx_Active=0, register oTx_Byte and pulse oTx_DV for 1 cycle, then go to WAIT_DONE.
- WAIT_DONE: on iTx_Done, rd_ptr+1 and byte count+1. If byte count equals DEPTH go to IDLE, else go to SEND.
- Output order: the first transmitted byte is the oldest pre-trigger sample; byte index pPreTrig is the trigger sample; exactly DEPTH bytes are sent.
- oTx_DV never asserts while iTx_Active=1 and never twice without an intervening iTx_Done.
- Simultaneous events: iArm together with iData_Valid in IDLE arms only; that sample is not stored.
- Flags: oArmed, oTriggered and oBusy are registered decodes of state, valid one cycle after the transition.

Optional Feature:
- Macro: TRIG_CAPTURE_HEADER_EN.
- When defined: before the first data byte, send a 3-byte frame of 0xA5, 0x5A, then trig_addr offset (= pPreTrig[7:0]). Each header byte uses the same SEND/WAIT_DONE handshake. A dump then totals DEPTH+3 bytes.
- When undefined: no header; the dump is exactly DEPTH bytes and no header logic is synthesized.

Test Plan (pAddrWidth=3, DEPTH=8, pPreTrig=2, pTrigLevel=128, uart_tx model with Active for 10 cycles then Done):
- Reset mid-dump: assert iRst_n=0 after 3 bytes sent → all outputs 0 immediately; after release, state is IDLE and no further oTx_DV appears.
- Basic capture: arm, feed 10,20,30,200,40,50,60,70,80 → trigger on 200. UART receives 20,30,200,40,50,60,70,80; oBusy falls after the 8th iTx_Done.
- No false trigger: arm, feed 200,210 (PRE), 220,130,140 → no trigger, because there is no below-to-at-or-above crossing. Then 100,128 → triggers on 128.
- Ignored inputs: iArm pulsed during POST and during SEND, and iData_Valid during SEND → no restart, no RAM write, dumped bytes unchanged.
- Backpressure: hold iTx_Active=1 for 50 cycles at SEND entry → oTx_DV stays 0; it pulses exactly once after Active falls.
- Wrap-around plus header: run 5 idle-gap samples in WAIT_TRIG so trig_addr=7 → read starts at address 5 and wraps 5,6,7,0..4. With TRIG_CAPTURE_HEADER_EN the stream is prefixed by A5 5A 02.
